// File: rtl/barker_pkg.sv
// Shared Barker code constants and width helper for the sliding correlator.
package barker_pkg;

    localparam logic [6:0]  BARKER_7  = 7'b1110010;
    localparam logic [10:0] BARKER_11 = 11'b11100010010;
    localparam logic [12:0] BARKER_13 = 13'b1111100110101;

    // Bits needed to hold a count in 0..len.
    function automatic int score_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/barker_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module barker_popcount #(
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0]           vec_i,
    output logic [$clog2(WIDTH+1)-1:0] cnt_o
);

    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/correlation_barker_sliding.sv
// Sliding-window Barker correlator: one scored beat out per accepted bit in,
// with tolerance-based detect flag and a per-packet hit counter.
module correlation_barker_sliding
    import barker_pkg::*;
#(
    parameter int SEQ_LEN    = 11,
    parameter     TARGET_SEQ = BARKER_11,
    parameter int MAX_ERR    = 0,
    parameter int CNT_W      = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         s_tdata,
    input  logic                         s_tvalid,
    input  logic                         s_tlast,
    output logic                         s_tready,
    output logic [score_w(SEQ_LEN)-1:0]  m_tdata,
    output logic                         m_tuser,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [CNT_W-1:0]             o_hit_cnt
);

    localparam int SW = score_w(SEQ_LEN);
    localparam logic [SEQ_LEN-1:0] TGT = SEQ_LEN'(TARGET_SEQ);

    if (SEQ_LEN < 2 || SEQ_LEN > 32) begin : g_bad_len
        $error("correlation_barker_sliding: SEQ_LEN must be in 2..32");
    end
    if (MAX_ERR < 0 || MAX_ERR >= SEQ_LEN) begin : g_bad_err
        $error("correlation_barker_sliding: MAX_ERR must be in 0..SEQ_LEN-1");
    end
    if ($bits(TARGET_SEQ) != SEQ_LEN) begin : g_bad_tgt
        $error("correlation_barker_sliding: TARGET_SEQ width must equal SEQ_LEN");
    end

    // Only the newest SEQ_LEN-1 bits need storing; the incoming bit completes the window.
    logic [SEQ_LEN-2:0] win_q, win_d;
    logic [SW-1:0]      fill_q, fill_d;
    logic               first_q, first_d;
    logic [SW-1:0]      tdata_q, tdata_d;
    logic               tuser_q, tuser_d;
    logic               tlast_q, tlast_d;
    logic               tvalid_q, tvalid_d;
    logic [CNT_W-1:0]   hit_q, hit_d;

    logic [SEQ_LEN-1:0] win_n;
    logic [SW-1:0]      fill_n;
    logic [SW-1:0]      mism;
    logic               det;
    logic               accept;

    assign s_tready = ~tvalid_q | m_tready;
    assign accept   = s_tvalid & s_tready;

    assign win_n  = {win_q, s_tdata};
    assign fill_n = (fill_q == SW'(SEQ_LEN)) ? fill_q : fill_q + SW'(1);

    barker_popcount #(.WIDTH(SEQ_LEN)) u_pop (
        .vec_i (win_n ^ TGT),
        .cnt_o (mism)
    );

    assign det = (fill_n == SW'(SEQ_LEN)) & (mism <= SW'(MAX_ERR));

    always_comb begin
        win_d    = win_q;
        fill_d   = fill_q;
        first_d  = first_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        hit_d    = hit_q;
        if (accept) begin
            // A tlast beat scores with its own bit, then clears history so codes never span packets.
            win_d    = s_tlast ? '0 : win_n[SEQ_LEN-2:0];
            fill_d   = s_tlast ? '0 : fill_n;
            first_d  = s_tlast;
            tdata_d  = SW'(SEQ_LEN) - mism;
            tuser_d  = det;
            tlast_d  = s_tlast;
            tvalid_d = 1'b1;
            if (first_q)
                hit_d = CNT_W'(det);
            else if (hit_q != '1)
                hit_d = hit_q + CNT_W'(det);
        end else if (m_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            win_q    <= '0;
            fill_q   <= '0;
            first_q  <= 1'b1;
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            hit_q    <= '0;
        end else begin
            win_q    <= win_d;
            fill_q   <= fill_d;
            first_q  <= first_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            hit_q    <= hit_d;
        end
    end

    assign m_tdata   = tdata_q;
    assign m_tuser   = tuser_q;
    assign m_tlast   = tlast_q;
    assign m_tvalid  = tvalid_q;
    assign o_hit_cnt = hit_q;

endmodule

// File: tb/tb_correlation_barker_sliding.sv
// Directed + randomized bench for the sliding Barker correlator (MAX_ERR=0 and MAX_ERR=1 instances).
module tb_correlation_barker_sliding;

    localparam int L = 11;
    localparam logic [10:0] CODE = 11'b11100010010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_tdata = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
    logic sr0, sr1, tu0, tu1, tl0, tl1, tv0, tv1;
    logic [3:0] td0, td1;
    logic [7:0] hc0, hc1;

    always #5 clk = ~clk;

    correlation_barker_sliding dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(sr0), .m_tdata(td0), .m_tuser(tu0),
        .m_tlast(tl0), .m_tvalid(tv0), .m_tready(m_tready), .o_hit_cnt(hc0));

    correlation_barker_sliding #(.MAX_ERR(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(sr1), .m_tdata(td1), .m_tuser(tu1),
        .m_tlast(tl1), .m_tvalid(tv1), .m_tready(m_tready), .o_hit_cnt(hc1));

    typedef struct {
        logic [3:0] sc0, sc1;
        logic       d0, d1, last;
        logic [7:0] h0, h1;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t expq[$];
    bit   pkt[$];
    int   hits0 = 0, hits1 = 0;
    int   stall_cnt = 0;
    bit   rand_rdy = 0;
    bit   held = 0;
    logic [31:0] snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: score the last L bits of the current packet (zero-padded) against CODE.
    task automatic model_accept(input bit d, input bit l);
        exp_t e;
        int   mism;
        bit   wb;
        pkt.push_back(d);
        mism = 0;
        for (int j = 0; j < L; j++) begin
            wb = (pkt.size() > j) ? pkt[pkt.size()-1-j] : 1'b0;
            if (wb != CODE[j]) mism++;
        end
        e.sc0  = 4'(L - mism);
        e.sc1  = 4'(L - mism);
        e.d0   = (pkt.size() >= L) && (mism <= 0);
        e.d1   = (pkt.size() >= L) && (mism <= 1);
        e.last = l;
        hits0  = (hits0 + int'(e.d0) > 255) ? 255 : hits0 + int'(e.d0);
        hits1  = (hits1 + int'(e.d1) > 255) ? 255 : hits1 + int'(e.d1);
        e.h0   = 8'(hits0);
        e.h1   = 8'(hits1);
        expq.push_back(e);
        if (l) begin
            pkt.delete();
            hits0 = 0;
            hits1 = 0;
        end
    endtask

    function automatic logic [31:0] outs();
        return {tv0, tu0, tl0, td0, hc0, tv1, tu1, tl1, td1, hc1};
    endfunction

    task automatic cycle(input bit d, input bit v, input bit l, input bit r, output bit acc);
        exp_t e;
        bit   ev;
        s_tdata = d; s_tvalid = v; s_tlast = l; m_tready = r;
        @(negedge clk);
        ev = (expq.size() != 0);
        if (held) chk("hold_stable", outs(), snap);
        held = tv0 && !r;
        snap = outs();
        chk("m_tvalid0", 32'(tv0), 32'(ev));
        chk("m_tvalid1", 32'(tv1), 32'(ev));
        chk("s_tready0", 32'(sr0), 32'(!ev || r));
        chk("s_tready1", 32'(sr1), 32'(!ev || r));
        if (ev && r) begin
            e = expq.pop_front();
            chk("beat0", {tu0, tl0, td0, hc0}, {e.d0, e.last, e.sc0, e.h0});
            chk("beat1", {tu1, tl1, td1, hc1}, {e.d1, e.last, e.sc1, e.h1});
        end
        acc = v && (!ev || r);
        if (acc) model_accept(d, l);
        @(posedge clk);
        #1;
    endtask

    function automatic bit next_ready();
        if (stall_cnt > 0) begin
            stall_cnt--;
            return 1'b0;
        end
        return rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    task automatic send(input bit d, input bit l);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        if (rand_rdy) while ($urandom_range(0, 3) == 0) cycle(0, 0, 0, next_ready(), acc);
        acc = 0;
        while (!acc && n < 64) begin
            cycle(d, 1, l, next_ready(), acc);
            n++;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_vec(input logic [31:0] v, input int n, input bit last_at_end);
        for (int i = n - 1; i >= 0; i--) send(v[i], last_at_end && (i == 0));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, acc);
    endtask

    initial begin
        logic [31:0] cw;
        int pre, suf;
        #2;
        chk("reset_outs", outs(), 32'd0);
        chk("reset_ready", {sr0, sr1}, 2'b11);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // 1: bare code as one packet
        send_vec(32'(CODE), L, 1);
        idle(2);
        // 2: 000 + code + 000000, then a short next packet
        send_vec(32'b000, 3, 0);
        send_vec(32'(CODE), L, 0);
        send_vec(32'b000000, 6, 1);
        send_vec(32'b101, 3, 1);
        // 3: one and two bit errors
        send_vec(32'(CODE ^ 11'b00000100000), L, 1);
        send_vec(32'(CODE ^ 11'b00000100100), L, 1);
        // 4: code split across packets
        send_vec(32'(CODE[10:5]), 6, 1);
        send_vec(32'(CODE[4:0]), 5, 1);
        // 5: downstream stall mid-code
        for (int i = L - 1; i >= 0; i--) begin
            if (i == 5) stall_cnt = 3;
            send(CODE[i], i == 0);
        end
        idle(2);
        // 6: async reset after 7 code bits
        send_vec(32'(CODE[10:4]), 7, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs(), 32'd0);
        expq.delete(); pkt.delete(); hits0 = 0; hits1 = 0; held = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_vec(32'(CODE[3:0]), 4, 0);
        send_vec(32'(CODE), L, 1);
        // random packets with embedded (possibly corrupted) codes
        rand_rdy = 1;
        for (int p = 0; p < 12; p++) begin
            pre = $urandom_range(0, 8);
            suf = $urandom_range(1, 5);
            cw = 32'(CODE);
            if ($urandom_range(0, 2) == 0) cw[$urandom_range(0, L - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) cw = $urandom;
            send_vec($urandom, pre, 0);
            send_vec(cw, L, 0);
            send_vec($urandom, suf, 1);
        end
        rand_rdy = 0;
        idle(3);
        chk("drain_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/correlation_barker_sliding.md
Name: correlation_barker_sliding

Overview:
Sliding-window Barker correlator, next generation of the team's packet-end Barker detector. Evaluates every accepted input bit against a parametrised target code, not only the tlast bit. Emits one output beat per input beat, carrying the match score, a detect flag under a configurable error tolerance, and a per-packet hit counter. Sits between the bit-serial demod stream and the frame-sync logic, with full AXI-Stream backpressure.

Parameters:
SEQ_LEN, 11, code length in bits (legal range 2..32)
TARGET_SEQ, 11'b11100010010, target code, SEQ_LEN bits wide; MSB is the oldest bit
MAX_ERR, 0, maximum mismatched bits still counted as a detect (0..SEQ_LEN-1)
CNT_W, 8, width of the per-packet hit counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low
s_tdata  in  1  input bit
s_tvalid  in  1  input valid
s_tlast  in  1  last bit of packet
s_tready  out  1  input ready
m_tdata  out  $clog2(SEQ_LEN+1)  score = number of matching bits in the window
m_tuser  out  1  detect flag
m_tlast  out  1  copy of s_tlast for this beat
m_tvalid  out  1  output valid
m_tready  in  1  output ready
o_hit_cnt  out  CNT_W  detects so far in the current packet

Behaviour:
- Reset: async assert, sync-safe deassert. Window, fill count, m_tdata, m_tuser, m_tlast, m_tvalid and o_hit_cnt all 0.
- s_tready = ~m_tvalid | m_tready. Combinational, no dependency on s_tvalid.
- Accept when s_tvalid & s_tready.
- On accept:
  - win_n = {win[SEQ_LEN-2:0], s_tdata}
  - fill_n = min(fill+1, SEQ_LEN), saturating
  - mism = popcount(win_n ^ TARGET_SEQ)
  - det = (fill_n == SEQ_LEN) & (mism <= MAX_ERR)
- Output register loads on the same edge as the accept: m_tdata = SEQ_LEN - mism, m_tuser = det, m_tlast = s_tlast, m_tvalid = 1. Latency is 1 cycle, throughput 1 beat/cycle.
- The score is always reported, even while the window is still filling. Unfilled positions are treated as 0.
- No accept and m_tready=1: m_tvalid <= 0. m_tvalid=1 and m_tready=0: all m_* outputs hold stable.
- Packet boundary: on an accepted s_tlast beat, the result is computed with that bit included. Then win <= 0 and fill <= 0, so a code split across two packets never detects.
- o_hit_cnt:
  - Updates with the output register.
  - First beat of a packet: loads det (0 or 1).
  - Other beats: adds det, saturating at 2^CNT_W-1.
  - On the tlast beat it shows the packet total, and holds that value until the next packet's first accepted beat.
  - "First beat" = first accept after reset or after an accepted tlast; tracked by a 1-bit register.
- Overlapping detects (e.g. with MAX_ERR>0) are each counted.
- Reset mid-packet: the packet is discarded and all state returns to reset values. The next accepted bit is a packet start.
- Illegal parameters (SEQ_LEN<2, MAX_ERR>=SEQ_LEN, TARGET_SEQ width mismatch) trigger an elaboration-time $error.

Decomposition:
- Package barker_pkg:
  - constants BARKER_7 = 7'b1110010, BARKER_11 = 11'b11100010010, BARKER_13 = 13'b1111100110101
  - function score_w(len) = $clog2(len+1)
- One sub-module: barker_popcount. Purely combinational; parameter WIDTH; input vector; output count of width $clog2(WIDTH+1).
- The top level owns all sequential state: window, fill, first-beat flag, output register, counter.

Test Plan:
1. Default params; 11-bit packet 11100010010, tlast on bit 11, m_tready=1. Expect 11 output beats, beat 11 with m_tdata=11, m_tuser=1, m_tlast=1, o_hit_cnt=1, and beats 1..10 with m_tuser=0.
2. 20-bit packet 000 + code + 000000, continuous. Expect detect only on beat 14 with score 11; o_hit_cnt=1 on the tlast beat; next packet's first beat shows o_hit_cnt=det of that beat.
3. MAX_ERR=1: code with bit 5 flipped gives m_tuser=1, m_tdata=10. Code with two bits flipped gives m_tuser=0, m_tdata=9.
4. Split code: first 6 code bits end packet A (tlast), last 5 start packet B. Expect no detect in either packet; o_hit_cnt=0 on both tlast beats.
5. Backpressure: stream the code, hold m_tready=0 for 3 cycles mid-stream. Expect s_tready=0 while m_tvalid=1, m_* stable, no bit lost or duplicated, detect still on the correct beat.
6. Reset: assert i_rst_n=0 asynchronously after 7 code bits. Expect all outputs 0 immediately. After release, the full code detects only after 11 new bits.
